digital_tube_ctrl: RTL and testbench

- Memory-mapped scan controller for the board's three seven-segment display groups.
- Holds a 32-bit hex value plus a control word written over the CPU bridge.
- Time-multiplexes digits 0–3 onto digital_tube0/1 with an inter-digit blanking gap and drives the single-digit digital_tube2 statically.
- Sits behind the system bridge as a peripheral, beside the LED and DIP-switch devices.

---
 rtl/digital_tube_ctrl.sv | 156 +++++++++++++++
 tb/tb_digital_tube_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digital_tube_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// digital_tube_ctrl : memory-mapped scan controller for three 7-segment groups
// Optional macro TUBE_DP_EN enables the CTRL[15:8] DP mask.   Rev 1.0
// ----------------------------------------------------------------------------
module digital_tube_ctrl #(
  parameter int unsigned SCAN_DIV  = 25000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [7:0]  digital_tube0_o,
  output logic [3:0]  digital_tube_sel0_o,
  output logic [7:0]  digital_tube1_o,
  output logic [3:0]  digital_tube_sel1_o,
  output logic [7:0]  digital_tube2_o,
  output logic        digital_tube_sel2_o
);

  localparam int unsigned   CW          = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] c_cnt_last  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] c_blank     = CW'(BLANK_CYC);
  localparam logic [CW-1:0] c_cnt_one   = CW'(1);
`ifdef TUBE_DP_EN
  localparam logic [31:0]   c_ctrl_mask = 32'hFFFF_FFFF;
`else
  localparam logic [31:0]   c_ctrl_mask = 32'hFFFF_00FF;
`endif

  typedef enum logic [1:0] {ST_OFF, ST_BLANK, ST_SHOW} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   data_q, ctrl_q;
  logic [7:0]    seg0_q, seg0_d, seg1_q, seg1_d, seg2_q, seg2_d;
  logic [3:0]    sel0_q, sel0_d, sel1_q, sel1_d;
  logic          sel2_q, sel2_d;
  logic          en;

  assign en = ctrl_q[0];

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    logic [7:0] s;
    s = 8'hFF;
    case (n)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  4'hF: s = 8'h8E;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!en) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == ST_OFF) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      if (cnt_q == c_cnt_last) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + c_cnt_one;
      end
      state_d = (cnt_d < c_blank) ? ST_BLANK : ST_SHOW;
    end
  end

  // Outputs are decoded from the next scan position so they line up with cnt/idx.
  always_comb begin
    sel0_d = 4'b0000;
    sel1_d = 4'b0000;
    seg0_d = 8'hFF;
    seg1_d = 8'hFF;
    if (state_d == ST_SHOW) begin
      sel0_d = 4'b0001 << idx_d;
      sel1_d = 4'b0001 << idx_d;
      seg0_d = hex_seg(data_q[{1'b0, idx_d, 2'b00} +: 4]);
      seg1_d = hex_seg(data_q[{1'b1, idx_d, 2'b00} +: 4]);
`ifdef TUBE_DP_EN
      seg0_d[7] = ~ctrl_q[{3'b010, idx_d}];
      seg1_d[7] = ~ctrl_q[{3'b011, idx_d}];
`endif
    end
    sel2_d = en;
    seg2_d = 8'hFF;
    if (en) begin
      seg2_d = ctrl_q[1] ? 8'hBF : hex_seg(ctrl_q[7:4]);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= 32'h0000_0000;
      ctrl_q  <= 32'h0000_0001;
      seg0_q  <= 8'hFF;
      seg1_q  <= 8'hFF;
      seg2_q  <= 8'hFF;
      sel0_q  <= 4'b0000;
      sel1_q  <= 4'b0000;
      sel2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg0_q  <= seg0_d;
      seg1_q  <= seg1_d;
      seg2_q  <= seg2_d;
      sel0_q  <= sel0_d;
      sel1_q  <= sel1_d;
      sel2_q  <= sel2_d;
      if (we_i) begin
        case (addr_i)
          2'd0:    data_q <= wdata_i;
          2'd1:    ctrl_q <= wdata_i & c_ctrl_mask;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_o = 32'h0000_0000;
    case (addr_i)
      2'd0:    rdata_o = data_q;
      2'd1:    rdata_o = ctrl_q;
      default: rdata_o = 32'h0000_0000;
    endcase
  end

  assign digital_tube0_o     = seg0_q;
  assign digital_tube1_o     = seg1_q;
  assign digital_tube2_o     = seg2_q;
  assign digital_tube_sel0_o = sel0_q;
  assign digital_tube_sel1_o = sel1_q;
  assign digital_tube_sel2_o = sel2_q;

endmodule
`default_nettype wire

// File: tb/tb_digital_tube_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_digital_tube_ctrl : bench with a position-based display model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_digital_tube_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;
`ifdef TUBE_DP_EN
  localparam logic [31:0] CTRL_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CTRL_MASK = 32'hFFFF_00FF;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  t0, t1, t2;
  logic [3:0]  sel0, sel1;
  logic        sel2;

  int tests = 0;
  int fails = 0;

  digital_tube_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk_i               (clk),
    .reset_i             (rst),
    .we_i                (we),
    .addr_i              (addr),
    .wdata_i             (wdata),
    .rdata_o             (rdata),
    .digital_tube0_o     (t0),
    .digital_tube_sel0_o (sel0),
    .digital_tube1_o     (t1),
    .digital_tube_sel1_o (sel1),
    .digital_tube2_o     (t2),
    .digital_tube_sel2_o (sel2)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seg_of(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
    endcase
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: register image plus the number of edges since the scan (re)started.
  logic [31:0] m_data, m_ctrl, e_data, e_ctrl;
  logic        m_active;
  int          m_pos;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data   <= 32'h0;
      m_ctrl   <= 32'h1;
      e_data   <= 32'h0;
      e_ctrl   <= 32'h0;
      m_active <= 1'b0;
      m_pos    <= 0;
    end else begin
      e_data <= m_data;
      e_ctrl <= m_ctrl;
      if (!m_ctrl[0]) begin
        m_active <= 1'b0;
        m_pos    <= 0;
      end else if (!m_active) begin
        m_active <= 1'b1;
        m_pos    <= 0;
      end else begin
        m_pos <= m_pos + 1;
      end
      if (we) begin
        if (addr == 2'd0)      m_data <= wdata;
        else if (addr == 2'd1) m_ctrl <= wdata & CTRL_MASK;
      end
    end
  end

  function automatic logic [31:0] mdl_read(input logic [1:0] a);
    if (a == 2'd0) return m_data;
    if (a == 2'd1) return m_ctrl;
    return 32'h0;
  endfunction

  initial begin : compare
    logic [31:0] sh;
    logic [3:0]  es;
    logic [7:0]  et0, et1, et2;
    int          slot, dig;
    forever begin
      @(negedge clk);
      slot = m_pos % SD;
      dig  = (m_pos / SD) % 4;
      es   = 4'b0000;
      et0  = 8'hFF;
      et1  = 8'hFF;
      if (e_ctrl[0] && slot >= BC) begin
        es  = 4'b0001 << dig;
        sh  = e_data >> (4 * dig);
        et0 = seg_of(sh[3:0]);
        sh  = e_data >> (4 * (dig + 4));
        et1 = seg_of(sh[3:0]);
`ifdef TUBE_DP_EN
        sh     = e_ctrl >> (8 + dig);
        et0[7] = ~sh[0];
        sh     = e_ctrl >> (12 + dig);
        et1[7] = ~sh[0];
`endif
      end
      et2 = !e_ctrl[0] ? 8'hFF : (e_ctrl[1] ? 8'hBF : seg_of(e_ctrl[7:4]));
      check("m_sel0", {28'h0, sel0}, {28'h0, es});
      check("m_sel1", {28'h0, sel1}, {28'h0, es});
      check("m_tube0", {24'h0, t0}, {24'h0, et0});
      check("m_tube1", {24'h0, t1}, {24'h0, et1});
      check("m_tube2", {24'h0, t2}, {24'h0, et2});
      check("m_sel2", {31'h0, sel2}, {31'h0, e_ctrl[0]});
      check("m_rdata", rdata, mdl_read(addr));
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    we = 1'b1; addr = a; wdata = d;
    #1;
    check("rd_old", rdata, mdl_read(a));
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] f0 [4];
    logic [7:0] f1 [4];
    int d, s, r;
    f0[0] = 8'hF9; f0[1] = 8'hA4; f0[2] = 8'hB0; f0[3] = 8'h99;
    f1[0] = 8'h83; f1[1] = 8'h88; f1[2] = 8'h90; f1[3] = 8'h80;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_sel0", {28'h0, sel0}, 32'h0);
    check("rst_tube0", {24'h0, t0}, 32'hFF);
    check("rst_sel2", {31'h0, sel2}, 32'h0);
    check("rst_tube2", {24'h0, t2}, 32'hFF);
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k >= 3 && k <= 8) begin
        check("boot_sel0", {28'h0, sel0}, 32'h1);
        check("boot_tube0", {24'h0, t0}, 32'hC0);
      end else begin
        check("boot_gap_sel0", {28'h0, sel0}, 32'h0);
      end
    end

    wr(2'd0, 32'h89AB_4321);
    wr(2'd1, 32'h0);
    wr(2'd1, 32'h1);
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      d = k / 8;
      s = k % 8;
      if (s < 2) begin
        check("frame_gap_sel0", {28'h0, sel0}, 32'h0);
        check("frame_gap_tube0", {24'h0, t0}, 32'hFF);
        check("frame_gap_tube1", {24'h0, t1}, 32'hFF);
      end else begin
        check("frame_sel0", {28'h0, sel0}, 32'h1 << d);
        check("frame_sel1", {28'h0, sel1}, 32'h1 << d);
        check("frame_tube0", {24'h0, t0}, {24'h0, f0[d]});
        check("frame_tube1", {24'h0, t1}, {24'h0, f1[d]});
      end
    end

    wr(2'd1, 32'h0);
    wr(2'd1, 32'h1);
    repeat (20) @(posedge clk);
    wr(2'd1, 32'h0);
    check("dis_still_lit", {28'h0, sel0}, 32'h4);
    @(posedge clk); #1;
    check("dis_sel0", {28'h0, sel0}, 32'h0);
    check("dis_sel1", {28'h0, sel1}, 32'h0);
    check("dis_tube0", {24'h0, t0}, 32'hFF);
    check("dis_sel2", {31'h0, sel2}, 32'h0);
    check("dis_tube2", {24'h0, t2}, 32'hFF);
    wr(2'd1, 32'h1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k < 3) begin
        check("reen_gap_sel0", {28'h0, sel0}, 32'h0);
      end else begin
        check("reen_sel0", {28'h0, sel0}, 32'h1);
        check("reen_tube0", {24'h0, t0}, 32'hF9);
      end
    end

    wr(2'd1, 32'h0000_00E1);
    @(posedge clk); #1;
    check("tube2_hex", {24'h0, t2}, 32'h86);
    check("tube2_sel", {31'h0, sel2}, 32'h1);
    wr(2'd1, 32'h0000_0003);
    @(posedge clk); #1;
    check("tube2_minus", {24'h0, t2}, 32'hBF);

    wr(2'd2, 32'hFFFF_FFFF);
    @(negedge clk); #1;
    addr = 2'd2; #1;
    check("rsv_rdata", rdata, 32'h0);
    addr = 2'd0; #1;
    check("rsv_data", rdata, 32'h89AB_4321);
    addr = 2'd1; #1;
    check("rsv_ctrl", rdata, 32'h3);

    wr(2'd0, 32'h0);
    wr(2'd1, 32'h0);
    wr(2'd1, 32'h0000_0301);
    addr = 2'd1; #1;
`ifdef TUBE_DP_EN
    check("dp_ctrl_rd", rdata, 32'h301);
`else
    check("dp_ctrl_rd", rdata, 32'h001);
`endif
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      if (k % 8 == 2) begin
`ifdef TUBE_DP_EN
        check("dp_tube0", {24'h0, t0}, (k < 16) ? 32'h40 : 32'hC0);
`else
        check("dp_tube0", {24'h0, t0}, 32'hC0);
`endif
      end
    end

    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #1;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        we  = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_sel0", {28'h0, sel0}, 32'h0);
        check("async_rst_tube0", {24'h0, t0}, 32'hFF);
        check("async_rst_sel2", {31'h0, sel2}, 32'h0);
        @(negedge clk); #1;
        rst = 1'b0;
      end else if (r < 14) begin
        we    = 1'b1;
        addr  = 2'($urandom_range(0, 3));
        wdata = $urandom;
        if (addr == 2'd1 && $urandom_range(0, 9) != 0) wdata[0] = 1'b1;
      end else begin
        we = 1'b0;
      end
    end
    @(negedge clk); #1;
    we = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
